// File: rtl/gb_vga_defs_pkg.sv
// Shared constants, FSM encoding and helpers for the Game Boy capture path.
package gb_vga_defs;

  localparam int GB_H_PIXELS = 160;
  localparam int GB_V_LINES  = 144;
  localparam int FB_ADDR_W   = 15;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PENDING = 2'd2
  } sched_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gb_edge_sync.sv
// Synchronizes one asynchronous GB pin and flags its falling edge.
module gb_edge_sync #(
  parameter int SYNC_STAGES = gb_vga_defs::SYNC_STAGES
) (
  input  logic CLK_25MHz,
  input  logic reset,
  input  logic pin,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  always_ff @(posedge CLK_25MHz or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign fe = hist_reg & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/gb_frame_scheduler.sv
// Captures GB LCD frames into ping-pong framebuffers and swaps the read side on VGA vblank.
module gb_frame_scheduler #(
  parameter int GB_H_PIXELS = gb_vga_defs::GB_H_PIXELS,
  parameter int GB_V_LINES  = gb_vga_defs::GB_V_LINES,
  parameter int FB_ADDR_W   = gb_vga_defs::FB_ADDR_W,
  parameter int SYNC_STAGES = gb_vga_defs::SYNC_STAGES
) (
  input  logic                 CLK_25MHz,
  input  logic                 reset,
  input  logic [1:0]           gb_dat,
  input  logic                 gb_px_clk,
  input  logic                 gb_hsync,
  input  logic                 gb_vsync,
  input  logic                 vga_vblank_start,
  output logic [1:0]           fb_wdata,
  output logic [FB_ADDR_W-1:0] fb_waddr,
  output logic [1:0]           fb_we,
  output logic                 fb_rd_sel,
  output logic                 swap_pulse,
  output logic [7:0]           frames_dropped,
  output logic [7:0]           last_lines
);

  import gb_vga_defs::*;

  localparam logic [7:0] H_CNT = 8'(GB_H_PIXELS);
  localparam logic [7:0] V_CNT = 8'(GB_V_LINES);

  logic px_fe, hs_fe, vs_fe;

  gb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_px_sync (
    .CLK_25MHz(CLK_25MHz), .reset(reset), .pin(gb_px_clk), .fe(px_fe));
  gb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hs_sync (
    .CLK_25MHz(CLK_25MHz), .reset(reset), .pin(gb_hsync), .fe(hs_fe));
  gb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vs_sync (
    .CLK_25MHz(CLK_25MHz), .reset(reset), .pin(gb_vsync), .fe(vs_fe));

  // Data runs through the same depth as the pixel clock so the last stage matches px_fe.
  logic [1:0] dat_sync_reg [SYNC_STAGES];

  always_ff @(posedge CLK_25MHz or posedge reset) begin
    if (reset) dat_sync_reg[0] <= 2'b00;
    else       dat_sync_reg[0] <= gb_dat;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_dat_chain
      always_ff @(posedge CLK_25MHz or posedge reset) begin
        if (reset) dat_sync_reg[gi] <= 2'b00;
        else       dat_sync_reg[gi] <= dat_sync_reg[gi-1];
      end
    end
  endgenerate

  sched_state_t         state_reg;
  logic [7:0]           col_reg, row_reg;
  logic [FB_ADDR_W-1:0] addr_reg;
  logic                 err_reg;

  // Pixel is resolved before the line end, line end before the frame end.
  logic       px_in_range, px_write, err_px, err_next;
  logic [7:0] col_px, col_next, row_next;

  always_comb begin
    px_in_range = (col_reg < H_CNT) && (row_reg < V_CNT);
    px_write    = (state_reg == CAPTURE) && px_fe && px_in_range;
    col_px      = px_fe ? sat_inc8(col_reg) : col_reg;
    err_px      = err_reg | (px_fe & ~px_in_range);
    err_next    = err_px;
    col_next    = col_px;
    row_next    = row_reg;
    if (hs_fe) begin
      err_next = err_px | (col_px != H_CNT);
      col_next = 8'd0;
      row_next = sat_inc8(row_reg);
    end
  end

  always_ff @(posedge CLK_25MHz or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      col_reg        <= 8'd0;
      row_reg        <= 8'd0;
      addr_reg       <= '0;
      err_reg        <= 1'b0;
      fb_we          <= 2'b00;
      fb_waddr       <= '0;
      fb_wdata       <= 2'b00;
      fb_rd_sel      <= 1'b0;
      swap_pulse     <= 1'b0;
      frames_dropped <= 8'd0;
      last_lines     <= 8'd0;
    end else begin
      fb_we      <= 2'b00;
      swap_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vs_fe) begin
            state_reg <= CAPTURE;
            col_reg   <= 8'd0;
            row_reg   <= 8'd0;
            addr_reg  <= '0;
            err_reg   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (px_write) begin
            fb_we    <= fb_rd_sel ? 2'b01 : 2'b10;
            fb_waddr <= addr_reg;
            fb_wdata <= dat_sync_reg[SYNC_STAGES-1];
            addr_reg <= addr_reg + FB_ADDR_W'(1);
          end
          col_reg <= col_next;
          row_reg <= row_next;
          err_reg <= err_next;
          if (vs_fe) begin
            last_lines <= row_next;
            if (row_next == V_CNT && !err_next) begin
              state_reg <= PENDING;
            end else begin
              frames_dropped <= sat_inc8(frames_dropped);
              col_reg        <= 8'd0;
              row_reg        <= 8'd0;
              addr_reg       <= '0;
              err_reg        <= 1'b0;
            end
          end
        end
        PENDING: begin
          if (vs_fe) frames_dropped <= sat_inc8(frames_dropped);
          if (vga_vblank_start) begin
            fb_rd_sel  <= ~fb_rd_sel;
            swap_pulse <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_frame_scheduler.sv
// Directed bench: full-size instance for the 160x144 frame and reset cases, 8x6 instance for the rest.
module tb_gb_frame_scheduler;

  logic       CLK_25MHz = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] gb_dat = 2'b00;
  logic       gb_px_clk = 1'b0;
  logic       gb_hsync = 1'b0;
  logic       gb_vsync = 1'b0;
  logic       vga_vblank_start = 1'b0;

  logic [1:0]  fb_wdata_b, fb_we_b, fb_wdata_s, fb_we_s;
  logic [14:0] fb_waddr_b, fb_waddr_s;
  logic        fb_rd_sel_b, swap_pulse_b, fb_rd_sel_s, swap_pulse_s;
  logic [7:0]  frames_dropped_b, last_lines_b, frames_dropped_s, last_lines_s;

  always #20 CLK_25MHz = ~CLK_25MHz;

  gb_frame_scheduler u_dut_big (
    .CLK_25MHz(CLK_25MHz), .reset(reset), .gb_dat(gb_dat), .gb_px_clk(gb_px_clk),
    .gb_hsync(gb_hsync), .gb_vsync(gb_vsync), .vga_vblank_start(vga_vblank_start),
    .fb_wdata(fb_wdata_b), .fb_waddr(fb_waddr_b), .fb_we(fb_we_b), .fb_rd_sel(fb_rd_sel_b),
    .swap_pulse(swap_pulse_b), .frames_dropped(frames_dropped_b), .last_lines(last_lines_b));

  gb_frame_scheduler #(.GB_H_PIXELS(8), .GB_V_LINES(6)) u_dut_small (
    .CLK_25MHz(CLK_25MHz), .reset(reset), .gb_dat(gb_dat), .gb_px_clk(gb_px_clk),
    .gb_hsync(gb_hsync), .gb_vsync(gb_vsync), .vga_vblank_start(vga_vblank_start),
    .fb_wdata(fb_wdata_s), .fb_waddr(fb_waddr_s), .fb_we(fb_we_s), .fb_rd_sel(fb_rd_sel_s),
    .swap_pulse(swap_pulse_s), .frames_dropped(frames_dropped_s), .last_lines(last_lines_s));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_data(input int a);
    return 2'(((a / 160) + (a % 160)) & 3);
  endfunction

  // Write monitors
  bit         mon_b_en = 1'b0;
  int         exp_addr_b = 0;
  logic [1:0] exp_we_b = 2'b10;
  int         wr_cnt_b = 0, swap_cnt_b = 0;
  int         wr_cnt_s = 0, swap_cnt_s = 0;
  logic [14:0] last_addr_s = '0;
  logic [1:0]  last_we_s = '0, last_data_s = '0;

  always @(negedge CLK_25MHz) begin
    if (fb_we_b != 2'b00) begin
      wr_cnt_b++;
      if (mon_b_en) begin
        check("big_addr", 32'(fb_waddr_b), exp_addr_b);
        check("big_data", 32'(fb_wdata_b), 32'(exp_data(exp_addr_b)));
        check("big_we", 32'(fb_we_b), 32'(exp_we_b));
        exp_addr_b++;
      end
    end
    if (swap_pulse_b) swap_cnt_b++;
  end

  always @(negedge CLK_25MHz) begin
    if (fb_we_s != 2'b00) begin
      wr_cnt_s++;
      last_addr_s = fb_waddr_s;
      last_we_s   = fb_we_s;
      last_data_s = fb_wdata_s;
    end
    if (swap_pulse_s) swap_cnt_s++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_25MHz);
  endtask

  task automatic send_px(input logic [1:0] d, input bit with_hs);
    @(negedge CLK_25MHz);
    gb_dat = d;
    gb_px_clk = 1'b1;
    if (with_hs) gb_hsync = 1'b1;
    @(negedge CLK_25MHz);
    gb_px_clk = 1'b0;
    if (with_hs) gb_hsync = 1'b0;
  endtask

  task automatic send_hs();
    @(negedge CLK_25MHz); gb_hsync = 1'b1;
    @(negedge CLK_25MHz); gb_hsync = 1'b0;
  endtask

  task automatic send_vs();
    @(negedge CLK_25MHz); gb_vsync = 1'b1;
    @(negedge CLK_25MHz); gb_vsync = 1'b0;
  endtask

  task automatic send_vblank();
    @(negedge CLK_25MHz); vga_vblank_start = 1'b1;
    @(negedge CLK_25MHz); vga_vblank_start = 1'b0;
  endtask

  // vblank lands on the same cycle the synchronized vsync edge is consumed
  task automatic send_vs_with_vblank();
    @(negedge CLK_25MHz); gb_vsync = 1'b1;
    @(negedge CLK_25MHz); gb_vsync = 1'b0;
    @(negedge CLK_25MHz);
    @(negedge CLK_25MHz); vga_vblank_start = 1'b1;
    @(negedge CLK_25MHz); vga_vblank_start = 1'b0;
  endtask

  task automatic send_line(input int r, input int n, input bit coinc);
    for (int c = 0; c < n; c++) send_px(2'((r + c) & 3), coinc && (c == n - 1));
    if (!coinc) send_hs();
  endtask

  task automatic do_reset();
    @(negedge CLK_25MHz); reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    wr_cnt_b = 0; swap_cnt_b = 0; wr_cnt_s = 0; swap_cnt_s = 0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    idle(4);
    check("rst_we", 32'(fb_we_b), 0);
    check("rst_waddr", 32'(fb_waddr_b), 0);
    check("rst_wdata", 32'(fb_wdata_b), 0);
    check("rst_rd_sel", 32'(fb_rd_sel_b), 0);
    check("rst_swap", 32'(swap_pulse_b), 0);
    check("rst_dropped", 32'(frames_dropped_b), 0);
    check("rst_last_lines", 32'(last_lines_b), 0);
    do_reset();

    // Full 160x144 frame into buffer 1
    mon_b_en = 1'b1; exp_addr_b = 0; exp_we_b = 2'b10;
    send_vs();
    for (int r = 0; r < 144; r++) send_line(r, 160, 1'b0);
    send_vs();
    idle(6);
    $display("T1 frame captured: writes=%0d last_lines=%0d", wr_cnt_b, last_lines_b);
    check("t1_writes", wr_cnt_b, 23040);
    check("t1_addr_end", exp_addr_b, 23040);
    check("t1_dropped", 32'(frames_dropped_b), 0);
    check("t1_last_lines", 32'(last_lines_b), 144);
    check("t1_no_early_swap", 32'(fb_rd_sel_b), 0);
    send_vblank();
    idle(3);
    $display("T1 vblank: rd_sel=%0d swaps=%0d", fb_rd_sel_b, swap_cnt_b);
    check("t1_rd_sel", 32'(fb_rd_sel_b), 1);
    check("t1_swap_cnt", swap_cnt_b, 1);

    // Reset mid-line at address 5000
    wr_cnt_b = 0; exp_addr_b = 0; exp_we_b = 2'b01;
    send_vs();
    for (int r = 0; r < 31; r++) send_line(r, 160, 1'b0);
    for (int c = 0; c < 40; c++) send_px(2'((31 + c) & 3), 1'b0);
    idle(6);
    check("t6_writes_before", wr_cnt_b, 5000);
    mon_b_en = 1'b0;
    send_px(2'd1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge CLK_25MHz); #1;
      if (fb_we_b != 2'b00) seen = 1'b1;
    end
    check("t6_we_seen", 32'(seen), 1);
    check("t6_waddr_5000", 32'(fb_waddr_b), 5000);
    reset = 1'b1;
    #1;
    $display("T6 reset mid-line: we=%0d waddr=%0d", fb_we_b, fb_waddr_b);
    check("t6_rst_we", 32'(fb_we_b), 0);
    check("t6_rst_waddr", 32'(fb_waddr_b), 0);
    check("t6_rst_rd_sel", 32'(fb_rd_sel_b), 0);
    idle(3);
    reset = 1'b0;
    idle(2);
    wr_cnt_b = 0;
    send_line(0, 10, 1'b0);
    idle(6);
    check("t6_idle_ignored", wr_cnt_b, 0);
    mon_b_en = 1'b1; exp_addr_b = 0; exp_we_b = 2'b10;
    send_vs();
    send_line(0, 3, 1'b0);
    idle(6);
    mon_b_en = 1'b0;
    $display("T6 restart: writes=%0d", wr_cnt_b);
    check("t6_restart_writes", wr_cnt_b, 3);
    check("t6_restart_addr_end", exp_addr_b, 3);

    // Short frame (5 of 6 lines) on the 8x6 instance
    do_reset();
    send_vs();
    for (int r = 0; r < 5; r++) send_line(r, 8, 1'b0);
    send_vs();
    idle(6);
    send_vblank();
    idle(3);
    $display("T2 short frame: dropped=%0d last_lines=%0d", frames_dropped_s, last_lines_s);
    check("t2_dropped", 32'(frames_dropped_s), 1);
    check("t2_last_lines", 32'(last_lines_s), 5);
    check("t2_writes", wr_cnt_s, 40);
    check("t2_rd_sel", 32'(fb_rd_sel_s), 0);
    check("t2_swap_cnt", swap_cnt_s, 0);
    send_line(0, 8, 1'b0);
    idle(6);
    check("t2_still_capture", wr_cnt_s, 48);
    check("t2_addr_cleared", 32'(last_addr_s), 7);

    // One over-long line (9 of 8 pixels)
    do_reset();
    send_vs();
    send_line(0, 9, 1'b0);
    for (int r = 1; r < 6; r++) send_line(r, 8, 1'b0);
    send_vs();
    idle(6);
    $display("T3 long line: writes=%0d dropped=%0d", wr_cnt_s, frames_dropped_s);
    check("t3_writes", wr_cnt_s, 48);
    check("t3_last_addr", 32'(last_addr_s), 47);
    check("t3_dropped", 32'(frames_dropped_s), 1);
    check("t3_last_lines", 32'(last_lines_s), 6);

    // Valid frame with vblank mid-capture and at the closing vsync, then PENDING drops
    do_reset();
    send_vs();
    for (int r = 0; r < 3; r++) send_line(r, 8, 1'b0);
    send_vblank();
    for (int r = 3; r < 5; r++) send_line(r, 8, 1'b0);
    send_line(5, 8, 1'b1);
    send_vs_with_vblank();
    idle(6);
    $display("T5 frame closed on vblank: writes=%0d rd_sel=%0d", wr_cnt_s, fb_rd_sel_s);
    check("t5_writes", wr_cnt_s, 48);
    check("t5_last_addr", 32'(last_addr_s), 47);
    check("t5_last_we", 32'(last_we_s), 2);
    check("t5_last_lines", 32'(last_lines_s), 6);
    check("t5_dropped", 32'(frames_dropped_s), 0);
    check("t5_rd_sel", 32'(fb_rd_sel_s), 0);
    check("t5_swap_cnt", swap_cnt_s, 0);
    send_vs();
    send_line(0, 8, 1'b0);
    send_vs();
    idle(6);
    $display("T4 pending: writes=%0d dropped=%0d", wr_cnt_s, frames_dropped_s);
    check("t4_no_pending_writes", wr_cnt_s, 48);
    check("t4_dropped", 32'(frames_dropped_s), 2);
    send_vblank();
    idle(3);
    check("t4_rd_sel", 32'(fb_rd_sel_s), 1);
    check("t4_swap_cnt", swap_cnt_s, 1);
    send_vs();
    send_line(3, 1, 1'b0);
    idle(6);
    $display("T4 restart: addr=%0d we=%0d data=%0d", last_addr_s, last_we_s, last_data_s);
    check("t4_restart_writes", wr_cnt_s, 49);
    check("t4_restart_addr", 32'(last_addr_s), 0);
    check("t4_restart_we", 32'(last_we_s), 1);
    check("t4_restart_data", 32'(last_data_s), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
